// File: rtl/slv_req_arbiter_pkg.sv
// Types and constants for slv_req_arbiter: state encodings, register struct with its
// reset value, and the requester-selection helper.
package slv_req_arbiter_pkg;

  import types_amba_pkg::*;

  localparam int unsigned NUM_REQ = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StReq  = ST_REQ,
    StResp = ST_RESP
  } arb_state_e;

  typedef struct packed {
    arb_state_e state;
    logic       owner;  // requester holding the grant
    logic       prio;   // round-robin favourite when both request
    logic       last;   // last flag of the beat currently awaiting response
  } arb_regs_t;

  localparam arb_regs_t ARB_REGS_RST = '{
    state: StIdle,
    owner: 1'b0,
    prio:  1'b0,
    last:  1'b0
  };

  // Only meaningful when at least one valid bit is set.
  function automatic logic sel_requester(logic [NUM_REQ-1:0] valid, logic fixed, logic prio);
    if (valid == 2'b11) begin
      return fixed ? 1'b0 : prio;
    end
    return valid[1];
  endfunction

endpackage

// File: rtl/types_amba_pkg.sv
// Shared system-bus width configuration.
// Provides address, data and strobe widths used by bus-side blocks.
package types_amba_pkg;

  localparam int unsigned CFG_SYSBUS_ADDR_BITS  = 32;
  localparam int unsigned CFG_SYSBUS_DATA_BITS  = 32;
  localparam int unsigned CFG_SYSBUS_DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8;

endpackage

// File: rtl/slv_req_arbiter.sv
// Two-requester arbiter in front of a single downstream bus slave.
// Grants one requester per burst, forwards one beat at a time and routes the
// matching response back to the grant owner.
// Ports:
//   i_clk, i_nrst                       clock, async active-low reset
//   i_req_* / o_req_ready               per-requester beat channel
//   o_resp_* / i_resp_ready             per-requester response channel (shared payload)
//   o_slv_req_* / i_slv_req_ready       downstream beat channel
//   i_slv_resp_* / o_slv_resp_ready     downstream response channel
//   o_owner, o_busy                     current grant, arbiter not idle
module slv_req_arbiter
  import types_amba_pkg::*;
  import slv_req_arbiter_pkg::*;
#(
  parameter bit fixed_prio = 1'b0
) (
  input  logic                                              i_clk,
  input  logic                                              i_nrst,
  input  logic [NUM_REQ-1:0]                                i_req_valid,
  output logic [NUM_REQ-1:0]                                o_req_ready,
  input  logic [NUM_REQ-1:0][CFG_SYSBUS_ADDR_BITS-1:0]      i_req_addr,
  input  logic [NUM_REQ-1:0]                                i_req_write,
  input  logic [NUM_REQ-1:0]                                i_req_last,
  input  logic [NUM_REQ-1:0][CFG_SYSBUS_DATA_BITS-1:0]      i_req_wdata,
  input  logic [NUM_REQ-1:0][CFG_SYSBUS_DATA_BYTES-1:0]     i_req_wstrb,
  output logic [NUM_REQ-1:0]                                o_resp_valid,
  input  logic [NUM_REQ-1:0]                                i_resp_ready,
  output logic [CFG_SYSBUS_DATA_BITS-1:0]                   o_resp_rdata,
  output logic                                              o_resp_err,
  output logic                                              o_slv_req_valid,
  input  logic                                              i_slv_req_ready,
  output logic [CFG_SYSBUS_ADDR_BITS-1:0]                   o_slv_req_addr,
  output logic                                              o_slv_req_write,
  output logic [CFG_SYSBUS_DATA_BITS-1:0]                   o_slv_req_wdata,
  output logic [CFG_SYSBUS_DATA_BYTES-1:0]                  o_slv_req_wstrb,
  output logic                                              o_slv_req_last,
  input  logic                                              i_slv_resp_valid,
  output logic                                              o_slv_resp_ready,
  input  logic [CFG_SYSBUS_DATA_BITS-1:0]                   i_slv_resp_rdata,
  input  logic                                              i_slv_resp_err,
  output logic                                              o_owner,
  output logic                                              o_busy
);

  arb_regs_t r_regs;
  arb_regs_t w_regs_d;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_regs <= ARB_REGS_RST;
    end else begin
      r_regs <= w_regs_d;
    end
  end

  always_comb begin
    w_regs_d         = r_regs;
    o_req_ready      = '0;
    o_resp_valid     = '0;
    o_resp_rdata     = '0;
    o_resp_err       = 1'b0;
    o_slv_req_valid  = 1'b0;
    o_slv_req_addr   = '0;
    o_slv_req_write  = 1'b0;
    o_slv_req_wdata  = '0;
    o_slv_req_wstrb  = '0;
    o_slv_req_last   = 1'b0;
    o_slv_resp_ready = 1'b0;

    unique case (r_regs.state)
      StIdle: begin
        // Grant is registered; the beat is forwarded from the next cycle on.
        if (|i_req_valid) begin
          w_regs_d.state = StReq;
          w_regs_d.owner = sel_requester(i_req_valid, fixed_prio, r_regs.prio);
        end
      end
      StReq: begin
        o_slv_req_valid              = i_req_valid[r_regs.owner];
        o_slv_req_addr               = i_req_addr[r_regs.owner];
        o_slv_req_write              = i_req_write[r_regs.owner];
        o_slv_req_wdata              = i_req_wdata[r_regs.owner];
        o_slv_req_wstrb              = i_req_wstrb[r_regs.owner];
        o_slv_req_last               = i_req_last[r_regs.owner];
        o_req_ready[r_regs.owner]    = i_slv_req_ready;
        if (i_req_valid[r_regs.owner] && i_slv_req_ready) begin
          w_regs_d.state = StResp;
          w_regs_d.last  = i_req_last[r_regs.owner];
        end
      end
      StResp: begin
        o_resp_valid[r_regs.owner] = i_slv_resp_valid;
        o_resp_rdata               = i_slv_resp_rdata;
        o_resp_err                 = i_slv_resp_err;
        o_slv_resp_ready           = i_resp_ready[r_regs.owner];
        if (i_slv_resp_valid && i_resp_ready[r_regs.owner]) begin
          if (r_regs.last) begin
            w_regs_d.state = StIdle;
            w_regs_d.prio  = ~r_regs.owner;
          end else begin
            // Grant is held until the burst's last beat has its response.
            w_regs_d.state = StReq;
          end
        end
      end
      default: begin
        w_regs_d = ARB_REGS_RST;
      end
    endcase
  end

  assign o_owner = r_regs.owner;
  assign o_busy  = (r_regs.state != StIdle);

endmodule

// File: tb/tb_slv_req_arbiter.sv
// Self-checking bench for slv_req_arbiter: a round-robin and a fixed-priority instance
// share random and directed stimulus and are compared every cycle against a
// transaction-level reference model.
module tb_slv_req_arbiter;

  import types_amba_pkg::*;

  localparam int AW = CFG_SYSBUS_ADDR_BITS;
  localparam int DW = CFG_SYSBUS_DATA_BITS;
  localparam int SW = CFG_SYSBUS_DATA_BYTES;

  typedef struct packed {
    logic [1:0]    req_ready;
    logic [1:0]    resp_valid;
    logic [DW-1:0] rdata;
    logic          err;
    logic          slv_valid;
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          last;
    logic          slv_resp_ready;
    logic          owner;
    logic          busy;
  } out_t;

  logic                   clk;
  logic                   nrst;
  logic [1:0]             req_valid, req_write, req_last, resp_ready;
  logic [1:0][AW-1:0]     req_addr;
  logic [1:0][DW-1:0]     req_wdata;
  logic [1:0][SW-1:0]     req_wstrb;
  logic                   slv_req_ready, slv_resp_valid, slv_resp_err;
  logic [DW-1:0]          slv_resp_rdata;

  logic [1:0][1:0]        d_req_ready, d_resp_valid;
  logic [1:0][DW-1:0]     d_resp_rdata, d_slv_wdata;
  logic [1:0][AW-1:0]     d_slv_addr;
  logic [1:0][SW-1:0]     d_slv_wstrb;
  logic [1:0]             d_resp_err, d_slv_valid, d_slv_write, d_slv_last;
  logic [1:0]             d_slv_resp_ready, d_owner, d_busy;

  slv_req_arbiter #(.fixed_prio(1'b0)) u_dut_rr (
    .i_clk(clk), .i_nrst(nrst),
    .i_req_valid(req_valid), .o_req_ready(d_req_ready[0]),
    .i_req_addr(req_addr), .i_req_write(req_write), .i_req_last(req_last),
    .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_resp_valid(d_resp_valid[0]), .i_resp_ready(resp_ready),
    .o_resp_rdata(d_resp_rdata[0]), .o_resp_err(d_resp_err[0]),
    .o_slv_req_valid(d_slv_valid[0]), .i_slv_req_ready(slv_req_ready),
    .o_slv_req_addr(d_slv_addr[0]), .o_slv_req_write(d_slv_write[0]),
    .o_slv_req_wdata(d_slv_wdata[0]), .o_slv_req_wstrb(d_slv_wstrb[0]),
    .o_slv_req_last(d_slv_last[0]),
    .i_slv_resp_valid(slv_resp_valid), .o_slv_resp_ready(d_slv_resp_ready[0]),
    .i_slv_resp_rdata(slv_resp_rdata), .i_slv_resp_err(slv_resp_err),
    .o_owner(d_owner[0]), .o_busy(d_busy[0])
  );

  slv_req_arbiter #(.fixed_prio(1'b1)) u_dut_fp (
    .i_clk(clk), .i_nrst(nrst),
    .i_req_valid(req_valid), .o_req_ready(d_req_ready[1]),
    .i_req_addr(req_addr), .i_req_write(req_write), .i_req_last(req_last),
    .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_resp_valid(d_resp_valid[1]), .i_resp_ready(resp_ready),
    .o_resp_rdata(d_resp_rdata[1]), .o_resp_err(d_resp_err[1]),
    .o_slv_req_valid(d_slv_valid[1]), .i_slv_req_ready(slv_req_ready),
    .o_slv_req_addr(d_slv_addr[1]), .o_slv_req_write(d_slv_write[1]),
    .o_slv_req_wdata(d_slv_wdata[1]), .o_slv_req_wstrb(d_slv_wstrb[1]),
    .o_slv_req_last(d_slv_last[1]),
    .i_slv_resp_valid(slv_resp_valid), .o_slv_resp_ready(d_slv_resp_ready[1]),
    .i_slv_resp_rdata(slv_resp_rdata), .i_slv_resp_err(slv_resp_err),
    .o_owner(d_owner[1]), .o_busy(d_busy[1])
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model: phase 0 = no grant, 1 = waiting to pass a beat, 2 = awaiting response.
  int m_phase [2];
  int m_owner [2];
  int m_prio  [2];
  int m_last  [2];
  bit is_fixed [2];
  int grants_rr[$];
  int grants_fp[$];
  int fwd_rr[$];
  int obs_beats;
  int obs_resps;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic out_t exp_out(int d);
    out_t e;
    int o;
    e = '0;
    o = m_owner[d];
    e.owner = (o == 1);
    e.busy  = (m_phase[d] != 0);
    if (m_phase[d] == 1) begin
      e.slv_valid    = req_valid[o];
      e.addr         = req_addr[o];
      e.write        = req_write[o];
      e.wdata        = req_wdata[o];
      e.wstrb        = req_wstrb[o];
      e.last         = req_last[o];
      e.req_ready[o] = slv_req_ready;
    end else if (m_phase[d] == 2) begin
      e.resp_valid[o]  = slv_resp_valid;
      e.rdata          = slv_resp_rdata;
      e.err            = slv_resp_err;
      e.slv_resp_ready = resp_ready[o];
    end
    return e;
  endfunction

  function automatic out_t obs_out(int d);
    out_t g;
    g.req_ready      = d_req_ready[d];
    g.resp_valid     = d_resp_valid[d];
    g.rdata          = d_resp_rdata[d];
    g.err            = d_resp_err[d];
    g.slv_valid      = d_slv_valid[d];
    g.addr           = d_slv_addr[d];
    g.write          = d_slv_write[d];
    g.wdata          = d_slv_wdata[d];
    g.wstrb          = d_slv_wstrb[d];
    g.last           = d_slv_last[d];
    g.slv_resp_ready = d_slv_resp_ready[d];
    g.owner          = d_owner[d];
    g.busy           = d_busy[d];
    return g;
  endfunction

  task automatic model_update(input int d);
    int o;
    o = m_owner[d];
    case (m_phase[d])
      0: if (req_valid != 2'b00) begin
        if (req_valid == 2'b11) o = is_fixed[d] ? 0 : m_prio[d];
        else o = req_valid[1] ? 1 : 0;
        m_owner[d] = o;
        m_phase[d] = 1;
        if (d == 0) grants_rr.push_back(o);
        else grants_fp.push_back(o);
      end
      1: if (req_valid[o] && slv_req_ready) begin
        m_phase[d] = 2;
        m_last[d]  = req_last[o] ? 1 : 0;
        if (d == 0) fwd_rr.push_back(o);
      end
      default: if (slv_resp_valid && resp_ready[o]) begin
        if (m_last[d] == 1) begin
          m_phase[d] = 0;
          m_prio[d]  = 1 - o;
        end else begin
          m_phase[d] = 1;
        end
      end
    endcase
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_owner[d] = 0; m_prio[d] = 0; m_last[d] = 0;
    end
    grants_rr.delete();
    grants_fp.delete();
    fwd_rr.delete();
  endtask

  // Check both DUTs at the falling edge, then advance the model with the same inputs.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("cycle_dut%0d", d), 128'(obs_out(d)), 128'(exp_out(d)));
    end
    if (d_slv_valid[0] && slv_req_ready) obs_beats++;
    if ((d_resp_valid[0] & resp_ready) != 2'b00) obs_resps++;
    if (nrst) begin
      for (int d = 0; d < 2; d++) model_update(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("reset_zero_dut%0d", d), 128'(obs_out(d)), '0);
    step();
    step();
    nrst = 1'b1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_write = '0; req_last = '0; resp_ready = '0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    slv_req_ready = 1'b0; slv_resp_valid = 1'b0; slv_resp_err = 1'b0; slv_resp_rdata = '0;
  endtask

  function automatic int count_owner0();
    int c;
    c = 0;
    foreach (fwd_rr[i]) if (fwd_rr[i] == 0) c++;
    return c;
  endfunction

  initial begin
    logic [AW-1:0] bp_addr;
    logic [DW-1:0] bp_rdata;
    int            rdy1_seen;
    int            g;
    clk = 1'b0;
    nrst = 1'b0;
    n_checks = 0;
    n_fail = 0;
    obs_beats = 0;
    obs_resps = 0;
    is_fixed[0] = 1'b0;
    is_fixed[1] = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    do_reset();

    // Single read from requester 0.
    req_valid = 2'b01; req_addr[0] = 32'h1000; req_write = 2'b00; req_last = 2'b01;
    slv_req_ready = 1'b1; slv_resp_valid = 1'b1; slv_resp_rdata = 32'hDEADBEEF;
    resp_ready = 2'b11;
    #1 check("rd_idle_slv_valid", 128'(d_slv_valid[0]), 128'(1'b0));
    step();
    check("rd_slv_valid", 128'(d_slv_valid[0]), 128'(1'b1));
    check("rd_slv_addr", 128'(d_slv_addr[0]), 128'(32'h1000));
    step();
    req_valid = 2'b00;
    #1 check("rd_resp_valid", 128'(d_resp_valid[0]), 128'(2'b01));
    check("rd_rdata", 128'(d_resp_rdata[0]), 128'(32'hDEADBEEF));
    step();
    check("rd_back_idle", 128'(d_busy[0]), 128'(1'b0));

    // Continuous contention with single beats.
    do_reset();
    req_valid = 2'b11; req_last = 2'b11; slv_req_ready = 1'b1; slv_resp_valid = 1'b1;
    resp_ready = 2'b11;
    repeat (12) step();
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      g = (i < grants_rr.size()) ? grants_rr[i] : -1;
      check($sformatf("rr_grant%0d", i), 128'(g), 128'(i % 2));
      g = (i < grants_fp.size()) ? grants_fp[i] : -1;
      check($sformatf("fp_grant%0d", i), 128'(g), 128'(0));
    end

    // Four-beat write burst from requester 0 while requester 1 waits.
    do_reset();
    req_valid = 2'b11; req_write = 2'b11; slv_req_ready = 1'b1; slv_resp_valid = 1'b1;
    resp_ready = 2'b11;
    rdy1_seen = 0;
    repeat (14) begin
      req_last[0] = (count_owner0() >= 3);
      req_last[1] = 1'b1;
      #1;
      if (count_owner0() < 4 && d_req_ready[0][1]) rdy1_seen++;
      step();
    end
    req_valid = 2'b00;
    check("burst_rdy1_zero", 128'(rdy1_seen), 128'(0));
    for (int i = 0; i < 5; i++) begin
      g = (i < fwd_rr.size()) ? fwd_rr[i] : -1;
      check($sformatf("burst_beat%0d", i), 128'(g), 128'((i < 4) ? 0 : 1));
    end

    // Backpressure on both downstream request and upstream response.
    do_reset();
    bp_addr = $urandom();
    bp_rdata = $urandom();
    req_valid = 2'b01; req_addr[0] = bp_addr; req_wdata[0] = $urandom(); req_write = 2'b01;
    req_last = 2'b01; req_wstrb[0] = 4'hF;
    slv_req_ready = 1'b0; slv_resp_valid = 1'b0; resp_ready = 2'b00;
    obs_beats = 0;
    obs_resps = 0;
    step();
    repeat (5) begin
      check("bp_slv_valid", 128'(d_slv_valid[0]), 128'(1'b1));
      check("bp_addr", 128'(d_slv_addr[0]), 128'(bp_addr));
      step();
    end
    slv_req_ready = 1'b1;
    step();
    req_valid = 2'b00; slv_req_ready = 1'b0; slv_resp_valid = 1'b1; slv_resp_rdata = bp_rdata;
    repeat (3) begin
      #1 check("bp_rdata", 128'(d_resp_rdata[0]), 128'(bp_rdata));
      step();
    end
    resp_ready = 2'b01;
    step();
    resp_ready = 2'b00; slv_resp_valid = 1'b0;
    repeat (3) step();
    check("bp_beats", 128'(obs_beats), 128'(1));
    check("bp_resps", 128'(obs_resps), 128'(1));

    // Reset while a burst response is pending.
    do_reset();
    req_valid = 2'b01; req_last = 2'b00; slv_req_ready = 1'b1; slv_resp_valid = 1'b0;
    resp_ready = 2'b11;
    step();
    step();
    check("pre_rst_busy", 128'(d_busy[0]), 128'(1'b1));
    do_reset();
    req_valid = 2'b11; req_last = 2'b11; slv_resp_valid = 1'b1;
    repeat (6) step();
    g = (grants_rr.size() > 0) ? grants_rr[0] : -1;
    check("post_rst_grant0", 128'(g), 128'(0));
    g = (grants_rr.size() > 1) ? grants_rr[1] : -1;
    check("post_rst_grant1", 128'(g), 128'(1));

    // Random traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_write = 2'($urandom_range(0, 3));
      req_last = 2'($urandom_range(0, 3));
      resp_ready = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        req_addr[k] = $urandom();
        req_wdata[k] = $urandom();
        req_wstrb[k] = 4'($urandom_range(0, 15));
      end
      slv_req_ready = 1'($urandom_range(0, 1));
      slv_resp_valid = 1'($urandom_range(0, 1));
      slv_resp_err = 1'($urandom_range(0, 1));
      slv_resp_rdata = $urandom();
      if ($urandom_range(0, 99) == 0) do_reset();
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
